adc_multi_capture: RTL
======================

// Module: adc_multi_capture
// PURPOSE
// Multi-channel serial-ADC front end for the acoustics array. Drives one shared chip-select and
// serial clock to N_CH ADCs and deserialises all data lines in parallel, one SAMPLE_W sample per
// channel per frame. Packed frames go into an internal FIFO with a sequence number.
// Sits between the ADC pins and the sample RAM/DSP; replaces the single-channel SIPO/controller/counter trio.
// PARAMETERS
// N_CH          4    number of ADC data lines captured simultaneously
// SAMPLE_W      10   data bits kept per channel per frame
// FRAME_BITS    16   serial clock periods per frame while cs is low
// LEAD_BITS     4    bits discarded at frame start (ADC leading zeros); LEAD_BITS+SAMPLE_W <= FRAME_BITS
// CLK_DIV_HALF  7    clk cycles per sclk half-period (>=1)
// CS_HIGH_PER   2    sclk periods cs is held high between frames (>=1)
// FIFO_DEPTH    16   FIFO entries, power of two
// SEQ_W         8    frame sequence counter width
// PORTS
// clk          in   1                clock, single domain
// reset_b      in   1                asynchronous active-low reset
// enable       in   1                1 = capture frames back to back
// sdata        in   N_CH             serial data from each ADC
// cs           out  1                ADC chip-select, active low
// sclk         out  1                ADC serial clock, idles high
// out_data     out  N_CH*SAMPLE_W    channel k in bits [k*SAMPLE_W +: SAMPLE_W]
// out_seq      out  SEQ_W            sequence number of out_data frame
// out_valid    out  1                FIFO head valid
// out_ready    in   1                consumer accepts head when out_valid & out_ready
// fill_level   out  clog2(DEPTH)+1   entries in FIFO
// overflow     out  1                sticky: a frame was dropped
// clear_ovf    in   1                synchronous clear of overflow and drop_cnt
// drop_cnt     out  16               dropped frames, saturates at 16'hFFFF
// BEHAVIOUR
// - Reset: cs=1, sclk=1, out_valid=0, fill_level=0, overflow=0, drop_cnt=0, seq=0, FSM=IDLE, all registers 0.
// - Divider: div_cnt counts 0..CLK_DIV_HALF-1; tick when div_cnt==CLK_DIV_HALF-1. Runs only outside IDLE. Reset to 0 on leaving IDLE.
// - FSM IDLE: cs=1, sclk=1. Go to QUIET when enable=1.
// - FSM QUIET: cs=1. Stay 2*CS_HIGH_PER ticks, then go to CONV with cs=0 and bit_idx=0.
// - FSM CONV: sclk toggles on every tick, starting with a falling edge.
//   * On each tick that drives sclk 0->1, sample sdata, which is registered once in sdata_q.
//   * If LEAD_BITS <= bit_idx < LEAD_BITS+SAMPLE_W, shift the bit MSB-first into each channel register.
//   * Increment bit_idx.
//   * On the rising edge with bit_idx==FRAME_BITS-1, go to PUSH. sclk stays 1 and cs goes high on the same clk edge.
// - FSM PUSH: one clk cycle. Write {seq, channel regs} to the FIFO. seq increments mod 2^SEQ_W whether or
//   not the write is accepted, so a gap in out_seq marks a drop. Then go to QUIET if enable=1, else IDLE.
// - enable=0 mid-frame: the current frame completes and is pushed; no new frame starts.
// - FIFO: show-ahead. out_data and out_seq are valid the same cycle out_valid=1. Pop when out_valid & out_ready.
// - FIFO full on push, no pop that cycle: frame dropped, overflow set, drop_cnt +1 (saturating).
// - FIFO full with push and pop in the same cycle: pop and push both happen, fill_level unchanged, no drop.
// - FIFO empty: out_valid=0; out_ready is ignored.
// - Pointers wrap mod FIFO_DEPTH. fill_level = pushes - pops.
// - clear_ovf in the same cycle as a drop: the clear wins, so overflow=0 and drop_cnt=0.
// - Frame period = 2*CLK_DIV_HALF*(FRAME_BITS+CS_HIGH_PER) + 1 clk cycles.
// - Reset asserted mid-frame: the outputs go to their reset values right away and the FIFO contents are discarded.
// STRUCTURE
// - Shared package adc_pkg: FSM state encoding (IDLE, QUIET, CONV, PUSH), and localparams FRAME_W = SEQ_W+N_CH*SAMPLE_W and FILL_W.
// - One sub-module, sample_fifo: parametrised WIDTH/DEPTH show-ahead FIFO with a full-drop policy reported to the parent.
// - The top holds the divider, FSM, bit counter, N_CH generated shift registers, seq and the overflow logic.
// TESTING
// - Reset then enable=1, defaults, per-ADC models serialising 0x000,0x155,0x2AA,0x3FF after 4 zero bits:
//   one frame has out_data=={10'h3FF,10'h2AA,10'h155,10'h000}, out_seq=0, 16 sclk rising edges with cs low.
// - Continuous run with out_ready=1: out_seq 0,1,2,... with no gaps.
//   Spacing between cs falling edges = 2*7*(16+2)+1 = 253 clk.
// - out_ready=0 for 20 frames: fill_level stops at 16, overflow=1, drop_cnt=4.
//   Then out_ready=1: seq 0..15 drain in order, the next frame has seq=20, then clear_ovf -> overflow=0, drop_cnt=0.
// - FIFO full with out_ready pulsed exactly on the PUSH cycle: no drop, fill_level stays 16.
// - enable dropped at bit_idx 8: the frame still completes and pushes, then cs=1, sclk=1 held in IDLE.
// - reset_b pulsed low at bit_idx 5 of a frame with 3 FIFO entries: cs=1, sclk=1, out_valid=0, fill_level=0 right away.
//   After release the first captured frame has seq=0.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared definitions for the multi-channel serial ADC capture front end.
// Default geometry and width helpers used by the top and its FIFO.
package adc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_QUIET = 2'd1,
      ST_CONV  = 2'd2,
      ST_PUSH  = 2'd3
   } adc_state_e;

   localparam int unsigned N_CH_DEF       = 4;
   localparam int unsigned SAMPLE_W_DEF   = 10;
   localparam int unsigned SEQ_W_DEF      = 8;
   localparam int unsigned FIFO_DEPTH_DEF = 16;

   localparam int unsigned FRAME_W = SEQ_W_DEF + N_CH_DEF * SAMPLE_W_DEF;
   localparam int unsigned FILL_W  = $clog2(FIFO_DEPTH_DEF) + 1;

   function automatic int unsigned frame_width(input int unsigned seq_w,
                                               input int unsigned n_ch,
                                               input int unsigned sample_w);
      return seq_w + n_ch * sample_w;
   endfunction

   function automatic int unsigned fill_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/sample_fifo.sv
// Show-ahead FIFO; a write into a full FIFO with no simultaneous pop is dropped
// and flagged on drop_o for one cycle.
module sample_fifo
   import adc_pkg::*;
#(
   parameter int unsigned WIDTH = FRAME_W,
   parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     reset_b,
   input  logic                     wr_en_i,
   input  logic [WIDTH-1:0]         wr_data_i,
   input  logic                     rd_ready_i,
   output logic [WIDTH-1:0]         rd_data_o,
   output logic                     rd_valid_o,
   output logic [$clog2(DEPTH):0]   fill_o,
   output logic                     drop_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             full, pop, wr_ok;

   assign full       = (cnt_q == CW'(DEPTH));
   assign rd_valid_o = (cnt_q != '0);
   assign pop        = rd_valid_o & rd_ready_i;
   // A pop in the same cycle frees the slot the write needs
   assign wr_ok      = wr_en_i & (~full | pop);
   assign drop_o     = wr_en_i & full & ~pop;
   assign rd_data_o  = mem_q[rd_ptr_q];
   assign fill_o     = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      unique case ({wr_ok, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (wr_ok) begin
            mem_q[wr_ptr_q] <= wr_data_i;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      end
   end

endmodule

// File: rtl/adc_multi_capture.sv
// Multi-channel serial ADC front end: shared cs/sclk generation, parallel
// deserialisation of N_CH data lines, sequence-numbered frames into a FIFO.
module adc_multi_capture
   import adc_pkg::*;
#(
   parameter int unsigned N_CH         = N_CH_DEF,
   parameter int unsigned SAMPLE_W     = SAMPLE_W_DEF,
   parameter int unsigned FRAME_BITS   = 16,
   parameter int unsigned LEAD_BITS    = 4,
   parameter int unsigned CLK_DIV_HALF = 7,
   parameter int unsigned CS_HIGH_PER  = 2,
   parameter int unsigned FIFO_DEPTH   = FIFO_DEPTH_DEF,
   parameter int unsigned SEQ_W        = SEQ_W_DEF
) (
   input  logic                         clk,
   input  logic                         reset_b,
   input  logic                         enable,
   input  logic [N_CH-1:0]              sdata,
   output logic                         cs,
   output logic                         sclk,
   output logic [N_CH*SAMPLE_W-1:0]     out_data,
   output logic [SEQ_W-1:0]             out_seq,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [$clog2(FIFO_DEPTH):0]  fill_level,
   output logic                         overflow,
   input  logic                         clear_ovf,
   output logic [15:0]                  drop_cnt
);

   localparam int unsigned DATA_W      = N_CH * SAMPLE_W;
   localparam int unsigned FW          = frame_width(SEQ_W, N_CH, SAMPLE_W);
   localparam int unsigned FLW         = fill_width(FIFO_DEPTH);
   localparam int unsigned QUIET_TICKS = 2 * CS_HIGH_PER;
   localparam int unsigned BIT_MAX     = (FRAME_BITS > QUIET_TICKS) ? FRAME_BITS : QUIET_TICKS;
   localparam int unsigned BIT_W       = $clog2(BIT_MAX + 1);
   localparam int unsigned DIV_W       = $clog2(CLK_DIV_HALF + 1);

   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV_HALF - 1);
   localparam logic [BIT_W-1:0] QUIET_LAST = BIT_W'(QUIET_TICKS - 1);
   localparam logic [BIT_W-1:0] FRAME_LAST = BIT_W'(FRAME_BITS - 1);
   localparam logic [BIT_W-1:0] KEEP_LO    = BIT_W'(LEAD_BITS);
   localparam logic [BIT_W-1:0] KEEP_HI    = BIT_W'(LEAD_BITS + SAMPLE_W);

   adc_state_e        state_q, state_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic              cs_q, cs_d, sclk_q, sclk_d;
   logic [N_CH-1:0]   sdata_q;
   logic [SEQ_W-1:0]  seq_q, seq_d;
   logic              ovf_q, ovf_d;
   logic [15:0]       drop_q, drop_d;
   logic              tick, shift_en, push, fifo_drop;
   logic [DATA_W-1:0] chan_flat;
   logic [FW-1:0]     fifo_rdata;

   assign tick = (state_q != ST_IDLE) && (div_q == DIV_LAST);

   // bit_q doubles as the tick counter while QUIET and the bit index while CONV
   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      bit_d    = bit_q;
      cs_d     = cs_q;
      sclk_d   = sclk_q;
      shift_en = 1'b0;
      push     = 1'b0;

      if (state_q == ST_IDLE || state_q == ST_PUSH) div_d = '0;
      else if (tick)                                 div_d = '0;
      else                                           div_d = div_q + DIV_W'(1);

      unique case (state_q)
         ST_IDLE: begin
            cs_d   = 1'b1;
            sclk_d = 1'b1;
            bit_d  = '0;
            if (enable) state_d = ST_QUIET;
         end
         ST_QUIET: begin
            if (tick) begin
               if (bit_q == QUIET_LAST) begin
                  state_d = ST_CONV;
                  bit_d   = '0;
                  cs_d    = 1'b0;
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end
         end
         ST_CONV: begin
            if (tick) begin
               sclk_d = ~sclk_q;
               if (!sclk_q) begin
                  shift_en = (bit_q >= KEEP_LO) && (bit_q < KEEP_HI);
                  bit_d    = bit_q + BIT_W'(1);
                  if (bit_q == FRAME_LAST) begin
                     state_d = ST_PUSH;
                     bit_d   = '0;
                     cs_d    = 1'b1;
                  end
               end
            end
         end
         ST_PUSH: begin
            push    = 1'b1;
            bit_d   = '0;
            state_d = enable ? ST_QUIET : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      seq_d  = push ? seq_q + SEQ_W'(1) : seq_q;
      ovf_d  = ovf_q;
      drop_d = drop_q;
      if (clear_ovf) begin
         ovf_d  = 1'b0;
         drop_d = '0;
      end else if (fifo_drop) begin
         ovf_d = 1'b1;
         if (drop_q != '1) drop_d = drop_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state_q <= ST_IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         cs_q    <= 1'b1;
         sclk_q  <= 1'b1;
         sdata_q <= '0;
         seq_q   <= '0;
         ovf_q   <= 1'b0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         cs_q    <= cs_d;
         sclk_q  <= sclk_d;
         sdata_q <= sdata;
         seq_q   <= seq_d;
         ovf_q   <= ovf_d;
         drop_q  <= drop_d;
      end
   end

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      logic [SAMPLE_W-1:0] sr_q;
      always_ff @(posedge clk or negedge reset_b) begin
         if (!reset_b)      sr_q <= '0;
         else if (shift_en) sr_q <= {sr_q[SAMPLE_W-2:0], sdata_q[k]};
      end
      assign chan_flat[k*SAMPLE_W +: SAMPLE_W] = sr_q;
   end

   sample_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset_b    (reset_b),
      .wr_en_i    (push),
      .wr_data_i  ({seq_q, chan_flat}),
      .rd_ready_i (out_ready),
      .rd_data_o  (fifo_rdata),
      .rd_valid_o (out_valid),
      .fill_o     (fill_level),
      .drop_o     (fifo_drop)
   );

   assign cs       = cs_q;
   assign sclk     = sclk_q;
   assign out_data = fifo_rdata[DATA_W-1:0];
   assign out_seq  = fifo_rdata[FW-1 -: SEQ_W];
   assign overflow = ovf_q;
   assign drop_cnt = drop_q;

   if (FLW != $clog2(FIFO_DEPTH) + 1) begin : g_bad_fill_w
      $error("fill width mismatch");
   end

endmodule
